// File: rtl/uart_byte_fifo_if.sv
// Handshake bundle between uart_RX, the byte FIFO and uart_TX.
// The master side is the surrounding loopback logic (RX/TX models); the
// slave side is the FIFO itself.
interface uart_byte_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  i_DV;
    logic [7:0]            i_BYTE;
    logic                  i_TX_ACTIVE;
    logic                  i_TX_DONE;
    logic                  i_CLR_OVF;
    logic                  o_DV;
    logic [7:0]            o_BYTE;
    logic [DEPTH_LOG2:0]   o_COUNT;
    logic                  o_EMPTY;
    logic                  o_FULL;
    logic                  o_OVERFLOW;

    modport master (
        output i_DV, i_BYTE, i_TX_ACTIVE, i_TX_DONE, i_CLR_OVF,
        input  o_DV, o_BYTE, o_COUNT, o_EMPTY, o_FULL, o_OVERFLOW
    );

    modport slave (
        input  i_DV, i_BYTE, i_TX_ACTIVE, i_TX_DONE, i_CLR_OVF,
        output o_DV, o_BYTE, o_COUNT, o_EMPTY, o_FULL, o_OVERFLOW
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// Elastic byte buffer between uart_RX and uart_TX in the loopback path.
// Bytes from RX are queued in a circular buffer; a small drain FSM launches
// one byte into TX and waits for TX completion before launching the next.
// Writes into a full buffer are dropped and flagged in a sticky overflow bit.
module uart_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    uart_byte_fifo_if.slave  bus
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } drain_state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    drain_state_t          state;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic                  overflow;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full/empty come only from the registered count, so the launch decision
    // and the drop decision both see the pre-edge occupancy.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = bus.i_DV && !full;
    assign pop   = (state == IDLE) && !empty && !bus.i_TX_ACTIVE;

    // Byte storage, written on every accepted push.
    // NOTE: the storage array has no reset; every entry is written before it can be read, and a reset on it would force flops instead of RAM.
    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_BYTE;
        end
    end

    // Pointer and occupancy bookkeeping; a push and a pop together leave count unchanged.
    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a dropped write wins over a clear in the same cycle.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            overflow <= 1'b0;
        end else if (bus.i_DV && full) begin
            overflow <= 1'b1;
        end else if (bus.i_CLR_OVF) begin
            overflow <= 1'b0;
        end
    end

    // Drain FSM: launch one byte, drop the strobe, then wait for TX completion.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state   <= IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        tx_dv   <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_dv <= 1'b0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_TX_DONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_dv <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_DV       = tx_dv;
    assign bus.o_BYTE     = tx_byte;
    assign bus.o_COUNT    = count;
    assign bus.o_EMPTY    = empty;
    assign bus.o_FULL     = full;
    assign bus.o_OVERFLOW = overflow;

endmodule
